// File: rtl/bundle_arbiter_if.sv
// Handshake and lane bundle shared between two requesters, the arbiter and one consumer.
// The slave view belongs to the arbiter; the master view is the surrounding environment.
interface bundle_arbiter_if #(
  parameter int WIDTH = 3
);
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_0;
  logic [WIDTH-1:0] in0_1;
  logic [WIDTH-1:0] in0_2;

  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_0;
  logic [WIDTH-1:0] in1_1;
  logic [WIDTH-1:0] in1_2;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_0;
  logic [WIDTH-1:0] out_1;
  logic [WIDTH-1:0] out_2;

  logic             grant;
  logic             busy;
  logic [1:0]       dbg_state;

  modport slave (
    input  in0_valid, in0_0, in0_1, in0_2,
    input  in1_valid, in1_0, in1_1, in1_2,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_0, out_1, out_2,
    output grant, busy, dbg_state
  );

  modport master (
    output in0_valid, in0_0, in0_1, in0_2,
    output in1_valid, in1_0, in1_1, in1_2,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_0, out_1, out_2,
    input  grant, busy, dbg_state
  );
endinterface

// File: rtl/bundle_arbiter.sv
// Two-requester round-robin arbiter steering one of two 3-lane bundles onto a shared output.
// Grants last up to BURST beats; every release passes through one IDLE cycle.
module bundle_arbiter #(
  parameter int WIDTH = 3,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  bundle_arbiter_if.slave    bus
);

  localparam int CW = (BURST > 2) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_last;
  logic          w_next_last;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;

  logic          w_own_valid;
  logic          w_beat;

  // Valid/ready: a beat transfers on a cycle where the owner's valid and the
  // consumer's ready are both high; the owner keeps its lanes stable while
  // valid is high and ready is low. Nothing transfers in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    case (r_state)
      S_OWN0:  w_own_valid = bus.in0_valid;
      S_OWN1:  w_own_valid = bus.in1_valid;
      default: w_own_valid = 1'b0;
    endcase
  end

  assign w_beat = w_own_valid & bus.out_ready;

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // With both requesting, the side that did not own last time wins.
        if (bus.in0_valid && (!bus.in1_valid || r_last)) begin
          w_next_state = S_OWN0;
          w_next_last  = 1'b0;
          w_next_cnt   = '0;
        end else if (bus.in1_valid) begin
          w_next_state = S_OWN1;
          w_next_last  = 1'b1;
          w_next_cnt   = '0;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!w_own_valid) begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end else if (w_beat) begin
          if (r_cnt == LAST_BEAT) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_0     = '0;
    bus.out_1     = '0;
    bus.out_2     = '0;
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    bus.grant     = r_last;
    case (r_state)
      S_OWN0: begin
        bus.out_valid = bus.in0_valid;
        bus.out_0     = bus.in0_0;
        bus.out_1     = bus.in0_1;
        bus.out_2     = bus.in0_2;
        bus.in0_ready = bus.out_ready;
        bus.grant     = 1'b0;
      end
      S_OWN1: begin
        bus.out_valid = bus.in1_valid;
        bus.out_0     = bus.in1_0;
        bus.out_1     = bus.in1_1;
        bus.out_2     = bus.in1_2;
        bus.in1_ready = bus.out_ready;
        bus.grant     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dbg_state = r_state;

endmodule
